// File: rtl/serial_rx_pkg.sv
// Shared serial-link definitions: receiver state encoding and idle line level.
// Reused by the matching transmitter.
package serial_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4,
        BREAK  = 3'd5
    } rx_state_t;

    localparam logic LINE_IDLE = 1'b1;

endpackage

// File: rtl/serial_rx_sync_2ff.sv
// Two-flop synchronizer for a single asynchronous input; both flops reset to RST_VAL.
module sync_2ff
    import serial_pkg::*;
#(
    parameter logic RST_VAL = LINE_IDLE
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            meta <= RST_VAL;
            q    <= RST_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/serial_rx.sv
// LSB-first serial receiver: start, DATA_W data bits, optional even parity, one stop bit.
// Define SERIAL_RX_PARITY_EN to include the parity bit and drive parity_err.
module serial_rx
    import serial_pkg::*;
#(
    parameter int DATA_W       = 8,
    parameter int CLKS_PER_BIT = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              rxd,
    output logic [DATA_W-1:0] data,
    output logic              valid,
    output logic              frame_err,
    output logic              parity_err,
    output logic              busy
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int BW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] IDX_LAST  = BW'(DATA_W - 1);

    rx_state_t         state, state_n;
    logic              rx_s;
    logic [CW-1:0]     cnt, cnt_n;
    logic [BW-1:0]     idx, idx_n;
    logic [DATA_W-1:0] shreg, shreg_n, shifted, data_n;
    logic [DATA_W:0]   ext;
    logic              valid_n, ferr_n;
`ifdef SERIAL_RX_PARITY_EN
    logic              pend, pend_n, perr_n;
`endif

    sync_2ff #(
        .RST_VAL(LINE_IDLE)
    ) u_sync (
        .clk  (clk),
        .reset(reset),
        .d    (rxd),
        .q    (rx_s)
    );

    // New bits enter at the MSB so the first received bit ends up in bit 0.
    assign ext     = {rx_s, shreg};
    assign shifted = ext[DATA_W:1];
    assign busy    = (state != IDLE);

    always_comb begin
        state_n = state;
        cnt_n   = cnt + 1'b1;
        idx_n   = idx;
        shreg_n = shreg;
        data_n  = data;
        valid_n = 1'b0;
        ferr_n  = 1'b0;
`ifdef SERIAL_RX_PARITY_EN
        pend_n  = pend;
        perr_n  = 1'b0;
`endif
        case (state)
            IDLE: begin
                cnt_n = '0;
`ifdef SERIAL_RX_PARITY_EN
                pend_n = 1'b0;
`endif
                if (!rx_s) state_n = START;
            end
            START: begin
                if (cnt == HALF_LAST) begin
                    cnt_n = '0;
                    idx_n = '0;
                    state_n = rx_s ? IDLE : DATA;
                end
            end
            DATA: begin
                if (cnt == BIT_LAST) begin
                    cnt_n   = '0;
                    shreg_n = shifted;
                    if (idx == IDX_LAST) begin
`ifdef SERIAL_RX_PARITY_EN
                        state_n = PARITY;
`else
                        state_n = STOP;
`endif
                    end else begin
                        idx_n = idx + 1'b1;
                    end
                end
            end
`ifdef SERIAL_RX_PARITY_EN
            PARITY: begin
                if (cnt == BIT_LAST) begin
                    cnt_n   = '0;
                    pend_n  = rx_s ^ (^shreg);
                    state_n = STOP;
                end
            end
`endif
            STOP: begin
                if (cnt == BIT_LAST) begin
                    cnt_n = '0;
                    if (rx_s) begin
                        state_n = IDLE;
`ifdef SERIAL_RX_PARITY_EN
                        if (pend) begin
                            perr_n = 1'b1;
                        end else begin
                            data_n  = shreg;
                            valid_n = 1'b1;
                        end
`else
                        data_n  = shreg;
                        valid_n = 1'b1;
`endif
                    end else begin
                        ferr_n  = 1'b1;
                        state_n = BREAK;
                    end
                end
            end
            BREAK: begin
                cnt_n = '0;
                if (rx_s) state_n = IDLE;
            end
            default: begin
                cnt_n   = '0;
                state_n = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= '0;
            idx       <= '0;
            shreg     <= '0;
            data      <= '0;
            valid     <= 1'b0;
            frame_err <= 1'b0;
`ifdef SERIAL_RX_PARITY_EN
            pend       <= 1'b0;
            parity_err <= 1'b0;
`endif
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            idx       <= idx_n;
            shreg     <= shreg_n;
            data      <= data_n;
            valid     <= valid_n;
            frame_err <= ferr_n;
`ifdef SERIAL_RX_PARITY_EN
            pend       <= pend_n;
            parity_err <= perr_n;
`endif
        end
    end

`ifndef SERIAL_RX_PARITY_EN
    assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_serial_rx.sv
// Self-checking bench for serial_rx (DATA_W=8, CLKS_PER_BIT=4); honours SERIAL_RX_PARITY_EN.
module tb_serial_rx;

    localparam int T  = 4;
    localparam int DW = 8;
`ifdef SERIAL_RX_PARITY_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif
    // Stop bit is bit index DW+PAR; START is entered 3 cycles after the line falls.
    localparam int NB       = DW + 1 + PAR;
    localparam int BUSY_EXP = T / 2 + NB * T;
    localparam int LAT      = 3 + BUSY_EXP;

    localparam int K_VALID = 0;
    localparam int K_FERR  = 1;
    localparam int K_PERR  = 2;

    typedef struct {
        int         kind;
        logic [7:0] d;
        int         cyc;
    } ev_t;

    typedef struct {
        logic [7:0] d;
        logic       stop;
        logic       par_ok;
        int         low_bits;
        int         gap_bits;
        logic       chk_busy;
        int         kind;
        logic [7:0] ed;
    } vec_t;

    logic          clk;
    logic          reset;
    logic          rxd;
    logic [DW-1:0] data;
    logic          valid;
    logic          frame_err;
    logic          parity_err;
    logic          busy;

    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;
    int   brun   = 0;
    int   busy_q[$];
    ev_t  exp_q[$];
    logic [7:0] last_good;

    serial_rx #(
        .DATA_W      (DW),
        .CLKS_PER_BIT(T)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .rxd       (rxd),
        .data      (data),
        .valid     (valid),
        .frame_err (frame_err),
        .parity_err(parity_err),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic got_pulse(input int k);
        ev_t e;
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_pulse: got kind %0d at cycle %0d, required no pulse", k, cyc);
        end else begin
            e = exp_q.pop_front();
            check("pulse_kind", k, e.kind);
            check("pulse_cycle", cyc, e.cyc);
            check("pulse_data", int'(data), int'(e.d));
        end
    endtask

    // Scoreboard side: every pulse must match the next expected frame outcome.
    always @(negedge clk) begin
        if (busy) begin
            brun++;
        end else if (brun > 0) begin
            busy_q.push_back(brun);
            brun = 0;
        end
        if (!reset) begin
            if (valid)      got_pulse(K_VALID);
            if (frame_err)  got_pulse(K_FERR);
            if (parity_err) got_pulse(K_PERR);
        end
    end

    task automatic tx_bit(input logic b);
        rxd = b;
        repeat (T) @(negedge clk);
    endtask

    // Called on a negedge; registers the expected outcome, then drives the frame.
    task automatic send_frame(input logic [7:0] d, input logic stop, input logic par_ok,
                              input int low_bits, input int gap_bits,
                              input int kind, input logic [7:0] ed);
        ev_t e;
        e.kind = kind;
        e.d    = ed;
        e.cyc  = cyc + LAT;
        exp_q.push_back(e);
        tx_bit(1'b0);
        for (int i = 0; i < DW; i++) tx_bit(d[i]);
`ifdef SERIAL_RX_PARITY_EN
        tx_bit(par_ok ? ^d : ~^d);
`endif
        tx_bit(stop);
        if (!stop) repeat (low_bits * T) @(negedge clk);
        if (gap_bits > 0) begin
            rxd = 1'b1;
            repeat (gap_bits * T) @(negedge clk);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_data"}, int'(data), 0);
        check({tag, "_valid"}, int'(valid), 0);
        check({tag, "_frame_err"}, int'(frame_err), 0);
        check({tag, "_parity_err"}, int'(parity_err), 0);
        check({tag, "_busy"}, int'(busy), 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl[$];
        logic [7:0] d;
        logic       stop, par_ok;
        int         kind, low, gap;

        rxd       = 1'b1;
        reset     = 1'b1;
        last_good = 8'h00;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset_state");
        reset = 1'b0;
        repeat (2 * T) @(negedge clk);

        tbl.push_back('{8'hA5, 1'b1, 1'b1, 0, 2, 1'b1, K_VALID, 8'hA5});
        tbl.push_back('{8'h3C, 1'b1, 1'b1, 0, 0, 1'b0, K_VALID, 8'h3C});
        tbl.push_back('{8'hC3, 1'b1, 1'b1, 0, 2, 1'b0, K_VALID, 8'hC3});
        tbl.push_back('{8'h5A, 1'b0, 1'b1, 3, 2, 1'b0, K_FERR,  8'hC3});
        tbl.push_back('{8'h00, 1'b1, 1'b1, 0, 2, 1'b1, K_VALID, 8'h00});
        tbl.push_back('{8'hFF, 1'b1, 1'b1, 0, 2, 1'b1, K_VALID, 8'hFF});
`ifdef SERIAL_RX_PARITY_EN
        tbl.push_back('{8'h07, 1'b1, 1'b1, 0, 2, 1'b1, K_VALID, 8'h07});
        tbl.push_back('{8'h07, 1'b1, 1'b0, 0, 2, 1'b1, K_PERR,  8'h07});
`endif
        foreach (tbl[i]) begin
            busy_q.delete();
            send_frame(tbl[i].d, tbl[i].stop, tbl[i].par_ok, tbl[i].low_bits,
                       tbl[i].gap_bits, tbl[i].kind, tbl[i].ed);
            if (tbl[i].chk_busy) begin
                check("busy_runs", busy_q.size(), 1);
                if (busy_q.size() > 0) check("busy_len", busy_q[0], BUSY_EXP);
            end
            if (tbl[i].gap_bits > 0) check("data_hold", int'(data), int'(tbl[i].ed));
        end
        last_good = 8'hFF;
`ifdef SERIAL_RX_PARITY_EN
        last_good = 8'h07;
`endif

        // Single-cycle low glitch while idle: short busy, no pulse.
        busy_q.delete();
        rxd = 1'b0;
        @(negedge clk);
        rxd = 1'b1;
        repeat (3 * T) @(negedge clk);
        check("glitch_busy_runs", busy_q.size(), 1);
        if (busy_q.size() > 0) check("glitch_busy_len", busy_q[0], T / 2);
        check("glitch_data", int'(data), int'(last_good));

        // Stop bit low and line held low: receiver must wait for the line to return high.
        send_frame(8'h5A, 1'b0, 1'b1, 3, 0, K_FERR, last_good);
        check("break_busy_while_low", int'(busy), 1);
        rxd = 1'b1;
        repeat (2 * T) @(negedge clk);
        check("break_busy_after_high", int'(busy), 0);
        check("break_data", int'(data), int'(last_good));

        // Reset in the middle of data bit 4 of 0xFF.
        check("pending_before_reset", exp_q.size(), 0);
        rxd = 1'b0;
        repeat (T) @(negedge clk);
        rxd = 1'b1;
        repeat (4 * T + T / 2) @(negedge clk);
        reset = 1'b1;
        #1;
        check_reset_outputs("async_reset");
        repeat (2) @(negedge clk);
        check_reset_outputs("held_reset");
        reset = 1'b0;
        last_good = 8'h00;
        repeat (2 * T) @(negedge clk);
        check("post_reset_busy", int'(busy), 0);
        send_frame(8'h12, 1'b1, 1'b1, 0, 2, K_VALID, 8'h12);
        last_good = 8'h12;
        check("post_reset_data", int'(data), 8'h12);

        // Randomized frames checked against frame-level outcome rules.
        for (int n = 0; n < 40; n++) begin
            d      = 8'($urandom);
            stop   = ($urandom_range(0, 7) != 0);
            par_ok = 1'b1;
`ifdef SERIAL_RX_PARITY_EN
            par_ok = ($urandom_range(0, 3) != 0);
`endif
            low  = stop ? 0 : $urandom_range(0, 3);
            gap  = stop ? $urandom_range(0, 2) : $urandom_range(1, 2);
            kind = !stop ? K_FERR : (!par_ok ? K_PERR : K_VALID);
            if (kind == K_VALID) last_good = d;
            send_frame(d, stop, par_ok, low, gap, kind, last_good);
        end
        rxd = 1'b1;
        repeat (3 * T) @(negedge clk);
        check("final_data", int'(data), int'(last_good));
        check("all_events_seen", exp_q.size(), 0);
        check("final_busy", int'(busy), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
